// File: rtl/loop_sdram_sched.sv
// Purpose : per-sample SDRAM access scheduler and mixer for the four-loop audio looper.
// Latency : tick -> frame_done is 18 clk for an idle frame, plus every waitrequest and read-latency cycle.
// Backpressure: holds sd_read/sd_write while sd_waitrequest; ticks seen outside IDLE are dropped and set overrun.
//
// Ports:
//   clk, reset                 system clock, synchronous active-low reset
//   sample_tick                one-clk pulse per audio sample (clk domain)
//   record, play, channel      mode and loop enables, latched on sample_tick
//   left_in, right_in          dry codec samples, latched on sample_tick
//   sd_*                       Avalon-style master (address/read/write/writedata,
//                              waitrequest/readdata/readdatavalid)
//   mix_left, mix_right        dry + sum of this frame's loop slot registers
//   frame_done                 one-clk pulse when mix outputs update
//   overrun                    sticky flag, tick arrived while busy
//
// Optional feature: define LOOP_OVERDUB_EN to turn record+play on an enabled loop
// into a read-modify-write (overdub). Without it, record+play is a per-slot no-op.

module loop_sdram_sched #(
  parameter int ADDR_W     = 25,
  parameter int MAX_FRAMES = 384000,
  parameter int BASE_ADDR  = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_tick,
  input  logic              record,
  input  logic              play,
  input  logic [3:0]        channel,
  input  logic [31:0]       left_in,
  input  logic [31:0]       right_in,
  output logic [ADDR_W-1:0] sd_address,
  output logic              sd_read,
  output logic              sd_write,
  output logic [31:0]       sd_writedata,
  input  logic              sd_waitrequest,
  input  logic [31:0]       sd_readdata,
  input  logic              sd_readdatavalid,
  output logic [31:0]       mix_left,
  output logic [31:0]       mix_right,
  output logic              frame_done,
  output logic              overrun
);

  localparam int FP_W = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;

  typedef enum logic [2:0] {
    IDLE,
    DECIDE,
    WR,
    RD,
    RWAIT,
    NEXT,
    DONE
  } state_t;

  state_t state, state_nx;

  // Inputs captured on the tick; the whole frame works from these copies so
  // that mid-frame changes on the live inputs only matter at the next tick.
  logic        lat_rec;
  logic        lat_play;
  logic [3:0]  lat_ch;
  logic [31:0] lat_left;
  logic [31:0] lat_right;

  logic [2:0]      slot;        // 0..7 = {loop[1:0], side}, side 0 = left
  logic [31:0]     slot_reg [8];
  logic [FP_W-1:0] frame_ptr;

  logic        en;
  logic [31:0] dry;
  logic        do_wr;
  logic        do_rd;
  logic        do_od;
  logic        active;
  logic [31:0] wr_data;

  // Per-slot decode, all from latched values.
  assign en    = lat_ch[slot[2:1]];
  assign dry   = slot[0] ? lat_right : lat_left;
  assign do_wr = en && lat_rec && !lat_play;
  assign do_rd = en && lat_play && !lat_rec;

`ifdef LOOP_OVERDUB_EN
  assign do_od   = en && lat_rec && lat_play;
  // In an overdub the slot register holds the just-read loop word, so the
  // write-back is old loop content plus the new dry sample.
  assign wr_data = do_od ? (slot_reg[slot] + dry) : dry;
  assign active  = (lat_rec | lat_play) && (|lat_ch);
`else
  assign do_od   = 1'b0;
  assign wr_data = dry;
  assign active  = (lat_rec ^ lat_play) && (|lat_ch);
`endif

  // Address is frame_ptr*8 + slot on top of the region base, wrapping at ADDR_W.
  assign sd_address = ADDR_W'(BASE_ADDR) + ADDR_W'({frame_ptr, 3'b000}) + ADDR_W'(slot);

  assign sd_write     = (state == WR);
  assign sd_read      = (state == RD);
  assign sd_writedata = (state == WR) ? wr_data : 32'h0;

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (sample_tick) state_nx = DECIDE;
      end
      DECIDE: begin
        if (do_wr)              state_nx = WR;
        else if (do_rd || do_od) state_nx = RD;
        else                    state_nx = NEXT;
      end
      WR: begin
        if (!sd_waitrequest) state_nx = NEXT;
      end
      RD: begin
        if (!sd_waitrequest) state_nx = RWAIT;
      end
      RWAIT: begin
        if (sd_readdatavalid) state_nx = do_od ? WR : NEXT;
      end
      NEXT: begin
        state_nx = (slot == 3'd7) ? DONE : DECIDE;
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      slot       <= 3'd0;
      frame_ptr  <= '0;
      lat_rec    <= 1'b0;
      lat_play   <= 1'b0;
      lat_ch     <= 4'h0;
      lat_left   <= 32'h0;
      lat_right  <= 32'h0;
      mix_left   <= 32'h0;
      mix_right  <= 32'h0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      for (int i = 0; i < 8; i++) slot_reg[i] <= 32'h0;
    end else begin
      state      <= state_nx;
      frame_done <= 1'b0;

      // Any tick that IDLE does not consume is lost; DONE counts as busy.
      if (sample_tick && (state != IDLE)) overrun <= 1'b1;

      case (state)
        IDLE: begin
          if (sample_tick) begin
            lat_rec   <= record;
            lat_play  <= play;
            lat_ch    <= channel;
            lat_left  <= left_in;
            lat_right <= right_in;
            slot      <= 3'd0;
          end
        end
        DECIDE: begin
          // A slot that neither plays nor overdubs contributes nothing to the mix.
          // A plain record leaves the slot register as it was.
          if (!(do_wr || do_rd || do_od)) slot_reg[slot] <= 32'h0;
        end
        RWAIT: begin
          if (sd_readdatavalid) slot_reg[slot] <= sd_readdata;
        end
        NEXT: begin
          if (slot != 3'd7) slot <= slot + 3'd1;
        end
        DONE: begin
          mix_left   <= lat_left  + slot_reg[0] + slot_reg[2] + slot_reg[4] + slot_reg[6];
          mix_right  <= lat_right + slot_reg[1] + slot_reg[3] + slot_reg[5] + slot_reg[7];
          frame_done <= 1'b1;
          // An inactive frame rewinds the loop so the next take starts at the top.
          if (active) begin
            frame_ptr <= (frame_ptr == FP_W'(MAX_FRAMES - 1)) ? '0 : frame_ptr + FP_W'(1);
          end else begin
            frame_ptr <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_loop_sdram_sched.sv
module tb_loop_sdram_sched;

  localparam int ADDR_W     = 25;
  localparam int MAX_FRAMES = 6;
  localparam int BASE_ADDR  = 0;
`ifdef LOOP_OVERDUB_EN
  localparam bit OVERDUB = 1'b1;
`else
  localparam bit OVERDUB = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              sample_tick;
  logic              record;
  logic              play;
  logic [3:0]        channel;
  logic [31:0]       left_in;
  logic [31:0]       right_in;
  logic [ADDR_W-1:0] sd_address;
  logic              sd_read;
  logic              sd_write;
  logic [31:0]       sd_writedata;
  logic              sd_waitrequest;
  logic [31:0]       sd_readdata;
  logic              sd_readdatavalid;
  logic [31:0]       mix_left;
  logic [31:0]       mix_right;
  logic              frame_done;
  logic              overrun;

  loop_sdram_sched #(
    .ADDR_W(ADDR_W), .MAX_FRAMES(MAX_FRAMES), .BASE_ADDR(BASE_ADDR)
  ) dut (
    .clk(clk), .reset(reset), .sample_tick(sample_tick),
    .record(record), .play(play), .channel(channel),
    .left_in(left_in), .right_in(right_in),
    .sd_address(sd_address), .sd_read(sd_read), .sd_write(sd_write),
    .sd_writedata(sd_writedata), .sd_waitrequest(sd_waitrequest),
    .sd_readdata(sd_readdata), .sd_readdatavalid(sd_readdatavalid),
    .mix_left(mix_left), .mix_right(mix_right),
    .frame_done(frame_done), .overrun(overrun)
  );

  always #10 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    bit                w;
    logic [ADDR_W-1:0] a;
    logic [31:0]       d;
  } acc_t;

  acc_t acc_q[$];
  acc_t exp_q[$];

  // Slave knobs
  int          stall_mode = 0;   // 0 none, 1 random, 2 always
  bit          lat_rand   = 1'b0;
  int          rd_lat     = 2;
  bit          stray_en   = 1'b0;
  logic [31:0] rd_off     = 32'h100;
  bit          rd_pending = 1'b0;
  int          rd_cnt     = 0;
  logic [31:0] rd_val     = 32'h0;

  // Reference model state
  int unsigned m_fp = 0;
  logic [31:0] m_slot [8];
  logic [31:0] exp_ml, exp_mr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_fp = 0;
    for (int i = 0; i < 8; i++) m_slot[i] = 32'h0;
  endtask

  // One frame of loop traffic computed straight from the slot rules:
  // which accesses happen, in what order, what the mix is, where the pointer goes.
  task automatic model_frame(input bit rec, input bit ply, input logic [3:0] ch,
                             input logic [31:0] l, input logic [31:0] r);
    exp_q.delete();
    for (int s = 0; s < 8; s++) begin
      bit                en;
      logic [31:0]       dry;
      logic [ADDR_W-1:0] a;
      en  = ch[s/2];
      dry = (s % 2 == 1) ? r : l;
      a   = ADDR_W'(BASE_ADDR + m_fp * 8 + s);
      if (en && rec && !ply) begin
        exp_q.push_back('{1'b1, a, dry});
      end else if (en && ply && !rec) begin
        exp_q.push_back('{1'b0, a, 32'h0});
        m_slot[s] = 32'(a) + rd_off;
      end else if (en && rec && ply && OVERDUB) begin
        exp_q.push_back('{1'b0, a, 32'h0});
        m_slot[s] = 32'(a) + rd_off;
        exp_q.push_back('{1'b1, a, m_slot[s] + dry});
      end else begin
        m_slot[s] = 32'h0;
      end
    end
    exp_ml = l + m_slot[0] + m_slot[2] + m_slot[4] + m_slot[6];
    exp_mr = r + m_slot[1] + m_slot[3] + m_slot[5] + m_slot[7];
    if ((OVERDUB ? (rec | ply) : (rec ^ ply)) && (ch != 4'h0))
      m_fp = (m_fp == MAX_FRAMES - 1) ? 0 : m_fp + 1;
    else
      m_fp = 0;
  endtask

  task automatic compare_frame(input string tag);
    check({tag, " mix_left"},  mix_left,  exp_ml);
    check({tag, " mix_right"}, mix_right, exp_mr);
    check({tag, " access count"}, acc_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < acc_q.size()) begin
        check($sformatf("%s acc%0d kind", tag, i), acc_q[i].w, exp_q[i].w);
        check($sformatf("%s acc%0d addr", tag, i), acc_q[i].a, exp_q[i].a);
        if (exp_q[i].w) check($sformatf("%s acc%0d data", tag, i), acc_q[i].d, exp_q[i].d);
      end
    end
  endtask

  // Avalon slave: random stalls, fixed or random read latency, stray readdatavalid.
  initial begin
    bit stall;
    sd_waitrequest   = 1'b0;
    sd_readdatavalid = 1'b0;
    sd_readdata      = 32'h0;
    forever begin
      @(posedge clk); #1;
      sd_readdatavalid = 1'b0;
      if (rd_pending) begin
        rd_cnt--;
        if (rd_cnt <= 0) begin
          sd_readdatavalid = 1'b1;
          sd_readdata      = rd_val;
          rd_pending       = 1'b0;
        end
      end else if (stray_en && $urandom_range(0, 3) == 0) begin
        sd_readdatavalid = 1'b1;
        sd_readdata      = $urandom;
      end
      if (sd_read || sd_write) begin
        stall = (stall_mode == 2) || (stall_mode == 1 && $urandom_range(0, 2) == 0);
        sd_waitrequest = stall;
        if (!stall) begin
          if (sd_write) begin
            acc_q.push_back('{1'b1, sd_address, sd_writedata});
          end else begin
            acc_q.push_back('{1'b0, sd_address, 32'h0});
            rd_pending = 1'b1;
            rd_val     = 32'(sd_address) + rd_off;
            rd_cnt     = lat_rand ? $urandom_range(1, 4) : rd_lat;
          end
        end
      end else begin
        sd_waitrequest = 1'b0;
      end
    end
  end

  // Called at posedge+2 with the DUT idle; returns tick->frame_done in clks.
  task automatic run_frame(input bit rec, input bit ply, input logic [3:0] ch,
                           input logic [31:0] l, input logic [31:0] r,
                           input bit scramble, input string tag, output int lat);
    model_frame(rec, ply, ch, l, r);
    acc_q.delete();
    record = rec; play = ply; channel = ch; left_in = l; right_in = r;
    sample_tick = 1'b1;
    @(posedge clk); #2;
    sample_tick = 1'b0;
    if (scramble) begin
      record = 1'($urandom); play = 1'($urandom); channel = 4'($urandom);
      left_in = $urandom; right_in = $urandom;
    end
    lat = 1;
    while (!frame_done && lat < 2000) begin
      @(posedge clk); #2;
      lat++;
    end
    check({tag, " frame_done seen"}, frame_done, 1'b1);
    compare_frame(tag);
    @(posedge clk); #2;
    check({tag, " frame_done one cycle"}, frame_done, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk); #2;
    @(posedge clk); #2;
    reset = 1'b1;
    rd_pending = 1'b0;
    model_reset();
    @(posedge clk); #2;
  endtask

  typedef struct {
    bit                rec;
    bit                ply;
    logic [3:0]        ch;
    logic [31:0]       l;
    logic [31:0]       r;
    logic [31:0]       off;
    int                nacc;
    logic [ADDR_W-1:0] a0;
    logic [31:0]       ml;
    logic [31:0]       mr;
  } vec_t;

  vec_t vt[7];

  initial begin
    int lat;
    int n;
    int done_seen;
    bit ok;

    reset = 1'b0; sample_tick = 1'b0; record = 1'b0; play = 1'b0;
    channel = 4'h0; left_in = 32'h0; right_in = 32'h0;

    //          rec  ply  ch       l      r      off   nacc a0 ml        mr
    vt[0] = '{1'b1, 1'b0, 4'b0001, 32'h11, 32'h22, 32'h100, 2, 0, 32'h11,  32'h22};
    vt[1] = '{1'b1, 1'b0, 4'b0001, 32'h33, 32'h44, 32'h100, 2, 8, 32'h33,  32'h44};
    vt[2] = '{1'b0, 1'b0, 4'b1111, 32'h5,  32'h6,  32'h100, 0, 0, 32'h5,   32'h6};
    vt[3] = '{1'b0, 1'b1, 4'b1010, 32'h0,  32'h0,  32'h100, 4, 2, 32'h208, 32'h20A};
    vt[4] = '{1'b1, 1'b0, 4'b0000, 32'h7,  32'h9,  32'h100, 0, 0, 32'h7,   32'h9};
`ifdef LOOP_OVERDUB_EN
    vt[5] = '{1'b1, 1'b1, 4'b0001, 32'h3,  32'h0,  32'h5,   4, 0, 32'h8,   32'h6};
    vt[6] = '{1'b1, 1'b0, 4'b0001, 32'h1,  32'h2,  32'h100, 2, 8, 32'h6,   32'h8};
`else
    vt[5] = '{1'b1, 1'b1, 4'b0001, 32'h3,  32'h0,  32'h5,   0, 0, 32'h3,   32'h0};
    vt[6] = '{1'b1, 1'b0, 4'b0001, 32'h1,  32'h2,  32'h100, 2, 0, 32'h1,   32'h2};
`endif

    do_reset();
    check("reset sd_read",      sd_read,      1'b0);
    check("reset sd_write",     sd_write,     1'b0);
    check("reset sd_address",   sd_address,   ADDR_W'(BASE_ADDR));
    check("reset sd_writedata", sd_writedata, 32'h0);
    check("reset mix_left",     mix_left,     32'h0);
    check("reset mix_right",    mix_right,    32'h0);
    check("reset frame_done",   frame_done,   1'b0);
    check("reset overrun",      overrun,      1'b0);

    // Directed table, no stalls, fixed read latency of 2.
    stall_mode = 0; lat_rand = 1'b0; rd_lat = 2; stray_en = 1'b0;
    for (int i = 0; i < 7; i++) begin
      rd_off = vt[i].off;
      run_frame(vt[i].rec, vt[i].ply, vt[i].ch, vt[i].l, vt[i].r, 1'b0,
                $sformatf("vec%0d", i), lat);
      check($sformatf("vec%0d table nacc", i), acc_q.size(), vt[i].nacc);
      if (vt[i].nacc > 0) check($sformatf("vec%0d table addr0", i), acc_q[0].a, vt[i].a0);
      else check($sformatf("vec%0d idle latency", i), lat, 18);
      check($sformatf("vec%0d table mix_left", i),  mix_left,  vt[i].ml);
      check($sformatf("vec%0d table mix_right", i), mix_right, vt[i].mr);
    end

    // Frame pointer wrap at MAX_FRAMES-1.
    do_reset();
    rd_off = 32'h100;
    for (int f = 0; f <= MAX_FRAMES; f++) begin
      run_frame(1'b1, 1'b0, 4'b0001, 32'hA0 + 32'(f), 32'hB0, 1'b0, $sformatf("wrap%0d", f), lat);
      if (acc_q.size() > 0)
        check($sformatf("wrap%0d first addr", f), acc_q[0].a, ADDR_W'((f % MAX_FRAMES) * 8));
    end

    // Tick while waiting for read data: dropped, overrun sticks, one frame_done.
    check("overrun before", overrun, 1'b0);
    rd_lat = 4;
    model_frame(1'b0, 1'b1, 4'b0001, 32'h1, 32'h2);
    acc_q.delete();
    record = 1'b0; play = 1'b1; channel = 4'b0001; left_in = 32'h1; right_in = 32'h2;
    sample_tick = 1'b1;
    @(posedge clk); #2;
    sample_tick = 1'b0;
    n = 0;
    while (!rd_pending && n < 100) begin @(posedge clk); #2; n++; end
    check("rwait reached", rd_pending, 1'b1);
    sample_tick = 1'b1;
    @(posedge clk); #2;
    sample_tick = 1'b0;
    check("overrun set", overrun, 1'b1);
    done_seen = 0;
    ok = 1'b0;
    for (int c = 0; c < 80; c++) begin
      if (frame_done) begin
        done_seen++;
        if (!ok) begin compare_frame("overrun frame"); ok = 1'b1; end
      end
      @(posedge clk); #2;
    end
    check("overrun frame_done count", done_seen, 1);
    check("overrun sticky", overrun, 1'b1);

    // Reset in the middle of a stalled write.
    stall_mode = 2;
    record = 1'b1; play = 1'b0; channel = 4'b0001; left_in = 32'h55; right_in = 32'h66;
    sample_tick = 1'b1;
    @(posedge clk); #2;
    sample_tick = 1'b0;
    n = 0;
    while (!sd_write && n < 100) begin @(posedge clk); #2; n++; end
    check("stalled write reached", sd_write, 1'b1);
    @(posedge clk); #2;
    @(posedge clk); #2;
    reset = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
    stall_mode = 0;
    rd_pending = 1'b0;
    model_reset();
    check("midwr sd_write",   sd_write,   1'b0);
    check("midwr sd_read",    sd_read,    1'b0);
    check("midwr sd_address", sd_address, ADDR_W'(BASE_ADDR));
    check("midwr overrun",    overrun,    1'b0);
    check("midwr mix_left",   mix_left,   32'h0);
    @(posedge clk); #2;
    run_frame(1'b1, 1'b0, 4'b0001, 32'h77, 32'h88, 1'b0, "post reset", lat);
    if (acc_q.size() > 0) check("post reset addr0", acc_q[0].a, ADDR_W'(BASE_ADDR));

    // Randomised frames with stalls, variable read latency, stray strobes and
    // inputs scrambled mid-frame.
    stall_mode = 1; lat_rand = 1'b1; stray_en = 1'b1;
    for (int i = 0; i < 150; i++) begin
      rd_off = $urandom;
      run_frame(1'($urandom), 1'($urandom), 4'($urandom), $urandom, $urandom, 1'b1,
                $sformatf("rand%0d", i), lat);
    end
    check("random overrun clear", overrun, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/loop_sdram_sched.md
Name: loop_sdram_sched

Overview:
- Per-sample scheduler for the shared SDRAM port used by the four-loop audio looper.
- On each audio sample tick, sequences up to 8 accesses: 4 loops x {left, right}. Each access is a read (play) or a write (record) on an Avalon-style master port with waitrequest/readdatavalid.
- Builds the per-sample loop mix. Sits between the codec sample interface and the SDRAM controller.

Parameters:
- ADDR_W, 25, SDRAM word address width
- MAX_FRAMES, 384000, loop length in sample frames (8 words per frame; 3072000 words total)
- BASE_ADDR, 0, first SDRAM word of the loop region

Ports:
- clk  in  1  system clock, 50 MHz
- reset  in  1  synchronous active-low reset
- sample_tick  in  1  one-clk pulse per 48 kHz sample, already in clk domain
- record  in  1  record request
- play  in  1  play request
- channel  in  4  loop select, bit k enables loop k
- left_in  in  32  codec left sample
- right_in  in  32  codec right sample
- sd_address  out  ADDR_W  SDRAM word address
- sd_read  out  1  read request
- sd_write  out  1  write request
- sd_writedata  out  32  write data
- sd_waitrequest  in  1  slave stall
- sd_readdata  in  32  read data
- sd_readdatavalid  in  1  read data strobe
- mix_left  out  32  dry left + sum of loop left reads
- mix_right  out  32  dry right + sum of loop right reads
- frame_done  out  1  one-clk pulse when mix updated
- overrun  out  1  sticky; tick arrived while busy

Behaviour:
- Reset: clk and reset are the only clock and reset. Synchronous active-low: sampled only on posedge clk. Effects:
  - FSM returns to IDLE, even mid-transfer.
  - sd_read, sd_write, frame_done, overrun = 0.
  - sd_address = BASE_ADDR; sd_writedata, mix_left, mix_right = 0.
  - frame_ptr = 0; all 8 slot registers = 0.
- States:
  - IDLE: on sample_tick, latch record, play, channel, left_in, right_in; set slot = 0; go to DECIDE.
  - DECIDE: k = slot[2:1], side = slot[0] (0 = left); en = latched channel[k].
    - en && record && !play: go to WR.
    - en && play && !record: go to RD.
    - Otherwise clear slot register and go to NEXT.
  - WR: sd_write = 1, sd_writedata = latched left/right per side. Hold address/data/write while sd_waitrequest = 1. Go to NEXT on first cycle with sd_waitrequest = 0.
  - RD: sd_read = 1 held while sd_waitrequest = 1. Go to RWAIT on accept.
  - RWAIT: on sd_readdatavalid, store sd_readdata into slot register; go to NEXT. Any readdatavalid outside RWAIT is ignored.
  - NEXT: if slot == 7, go to DONE; else slot += 1 and go to DECIDE.
  - DONE: update mix_left/mix_right, pulse frame_done for one cycle, advance frame_ptr, return to IDLE.
- Address: sd_address = BASE_ADDR + frame_ptr*8 + slot. Computed at ADDR_W bits, truncating.
- Frame pointer update in DONE:
  - active = (record ^ play) && |channel, using latched values.
  - If active: frame_ptr = (frame_ptr == MAX_FRAMES-1) ? 0 : frame_ptr + 1.
  - Else frame_ptr = 0.
- Mix: mix_left = left_in + slot0 + slot2 + slot4 + slot6; mix_right = left/right counterpart using odd slots. Sum is modulo 2^32 with no saturation. Mix outputs hold between frames.
- Busy: a sample_tick outside IDLE is dropped and sets overrun (sticky until reset). A sample_tick in the DONE cycle is also dropped.
- Latency: idle frame (no enables) takes tick -> frame_done in 18 clks. Every access adds its waitrequest and read-latency cycles.
- Changes to record/play/channel during a frame take effect at the next tick.

Optional Feature:
- Macro: LOOP_OVERDUB_EN.
- Defined: en && record && play performs overdub for the slot. First RD/RWAIT; then WR with sd_writedata = readdata + dry sample (mod 2^32). The slot register keeps the pre-sum readdata. active becomes (record | play) && |channel.
- Undefined: record && play together is a no-op per slot (slot cleared) and frame_ptr resets to 0.

Test Plan:
- Reset mid-WR (sd_waitrequest held 1), then reset low one clk -> next cycle sd_write = 0, sd_address = 0, frame_ptr = 0, overrun = 0.
- record = 1, play = 0, channel = 4'b0001, left_in = 0x11, right_in = 0x22, waitrequest = 0 -> writes 0x11 @ addr 0 and 0x22 @ addr 1 only; next tick uses addrs 8, 9.
- play = 1, channel = 4'b1010, slave returns readdata = address+0x100 after 2 clks -> reads at 2, 3, 6, 7. Mix with zero dry input: mix_left = 0x102 + 0x106 = 0x208, mix_right = 0x103 + 0x107 = 0x20A.
- frame_ptr preset by MAX_FRAMES-1 ticks with record, channel = 1 -> last write at 8*(MAX_FRAMES-1); following frame writes addr 0.
- sample_tick asserted while in RWAIT -> overrun = 1 and stays 1; frame completes normally, one frame_done.
- LOOP_OVERDUB_EN, record = play = 1, channel = 1, readdata = 5, left_in = 3 -> read then write 8 @ addr 0; without macro, no sd_read/sd_write and frame_ptr stays 0.
